// File: rtl/pe_types.sv
// Shared types for the PE result drain.
// Holds the drain state enum and the beat-count helper.
package pe_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    OWN  = 2'd2
  } drain_state_t;

  function automatic int beat_count(input int accum, input int lanes);
    return (accum + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/pe_stream_reg.sv
// Single register stage for a valid/ready stream.
// Ports: i_valid/i_data in, o_valid/o_data out, i_ready from sink, o_load = stage accepts.
module pe_stream_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_load
);

  assign o_load = !o_valid || i_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (o_load) begin
      o_valid <= i_valid;
      if (i_valid) o_data <= i_data;
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// Drains a PE's accumulator bank onto a daisy-chained result stream.
// Ports: clock/resetn, i_capture/i_result/i_bypass, upstream i_up_*, downstream o_dn_*, o_busy, o_err_capture.
module pe_result_drain
  import pe_types::*;
#(
  parameter int NUM_ACCUM    = 8,
  parameter int NUM_LANES    = 4,
  parameter int RESULT_WIDTH = 32,
  parameter int IS_HEAD      = 0
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              i_capture,
  input  logic [NUM_ACCUM*RESULT_WIDTH-1:0] i_result,
  input  logic                              i_bypass,
  input  logic                              i_up_valid,
  input  logic [NUM_LANES*RESULT_WIDTH-1:0] i_up_data,
  input  logic [NUM_LANES-1:0]              i_up_mask,
  input  logic                              i_up_last,
  output logic                              o_up_ready,
  output logic                              o_dn_valid,
  output logic [NUM_LANES*RESULT_WIDTH-1:0] o_dn_data,
  output logic [NUM_LANES-1:0]              o_dn_mask,
  output logic                              o_dn_last,
  input  logic                              i_dn_ready,
  output logic                              o_busy,
  output logic                              o_err_capture
);

  localparam int BEATS = beat_count(NUM_ACCUM, NUM_LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = NUM_LANES * RESULT_WIDTH;
  localparam int PW    = DW + NUM_LANES + 1;
  localparam int BW    = NUM_ACCUM * RESULT_WIDTH;

  drain_state_t       state_q;
  logic [CW-1:0]      cnt_q;
  logic               byp_q;
  logic               sent_q;
  logic               err_q;
  logic [BW-1:0]      bank_q;

  logic [BEATS*DW-1:0] padded;
  logic [DW-1:0]       own_data;
  logic [NUM_LANES-1:0] own_mask;
  logic                own_last;

  logic               load;
  logic               in_valid;
  logic [DW-1:0]      in_data;
  logic [NUM_LANES-1:0] in_mask;
  logic               in_last;
  logic [PW-1:0]      q;
  logic               up_xfer;
  logic               dn_xfer;

  // Bank is zero-padded to whole beats so the tail lanes read as 0.
  always_comb begin
    padded = '0;
    padded[BW-1:0] = bank_q;
    own_data = padded[int'(cnt_q)*DW +: DW];
    for (int l = 0; l < NUM_LANES; l++) begin
      own_mask[l] = (int'(cnt_q) * NUM_LANES + l) < NUM_ACCUM;
    end
    own_last = (cnt_q == CW'(BEATS - 1));
  end

  // sent_q: final beat is in the output stage, waiting to be taken.
  assign o_up_ready = (IS_HEAD == 0) && (state_q == FWD)
                   && !sent_q && load;
  assign up_xfer = i_up_valid && o_up_ready;
  assign dn_xfer = o_dn_valid && i_dn_ready;

  always_comb begin
    in_valid = 1'b0;
    in_data  = '0;
    in_mask  = '0;
    in_last  = 1'b0;
    unique case (state_q)
      FWD: begin
        in_valid = i_up_valid && !sent_q && (IS_HEAD == 0);
        in_data  = i_up_data;
        in_mask  = i_up_mask;
        in_last  = byp_q && i_up_last;
      end
      OWN: begin
        in_valid = !sent_q;
        in_data  = own_data;
        in_mask  = own_mask;
        in_last  = own_last;
      end
      default: ;
    endcase
  end

  pe_stream_reg #(
    .WIDTH (PW)
  ) u_out (
    .clock   (clock),
    .resetn  (resetn),
    .i_valid (in_valid),
    .i_data  ({in_last, in_mask, in_data}),
    .i_ready (i_dn_ready),
    .o_valid (o_dn_valid),
    .o_data  (q),
    .o_load  (load)
  );

  assign o_dn_last = q[PW-1];
  assign o_dn_mask = q[DW +: NUM_LANES];
  assign o_dn_data = q[DW-1:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byp_q   <= 1'b0;
      sent_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (i_capture && state_q != IDLE) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          sent_q <= 1'b0;
          if (i_capture) begin
            byp_q <= i_bypass;
            // A bypassed head has nothing to send at all.
            if (IS_HEAD == 0)  state_q <= FWD;
            else if (!i_bypass) state_q <= OWN;
          end
        end
        FWD: begin
          if (sent_q) begin
            if (dn_xfer) state_q <= IDLE;
          end else if (up_xfer && i_up_last) begin
            if (byp_q) sent_q  <= 1'b1;
            else       state_q <= OWN;
          end
        end
        OWN: begin
          if (sent_q) begin
            if (dn_xfer) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end else if (load) begin
            if (own_last) sent_q <= 1'b1;
            else          cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == IDLE && i_capture && !i_bypass) bank_q <= i_result;
  end

  assign o_busy        = (state_q != IDLE);
  assign o_err_capture = err_q;

endmodule

// File: doc/pe_result_drain.md
PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

Interface
REQ-001 SHALL have parameter NUM_ACCUM, default 8: results held per PE (NUM_DOTS*NUM_FEATURES*NUM_FILTERS).
REQ-002 SHALL have parameter NUM_LANES, default 4: results per output beat (NUM_RESULTS_PER_CYCLE), 1..NUM_ACCUM.
REQ-003 SHALL have parameter RESULT_WIDTH, default 32: bits per result.
REQ-004 SHALL have parameter IS_HEAD, default 0: 1 = first PE in chain, upstream inputs ignored.
REQ-005 SHALL have ports: clock in 1, clock; resetn in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: i_capture in 1, snapshot i_result; i_result in NUM_ACCUM*RESULT_WIDTH, accumulator values; i_bypass in 1, PE contributes no results.
REQ-007 SHALL have ports: i_up_valid in 1, i_up_data in NUM_LANES*RESULT_WIDTH, i_up_mask in NUM_LANES, i_up_last in 1, o_up_ready out 1; these form the upstream stream.
REQ-008 SHALL have ports: o_dn_valid out 1, o_dn_data out NUM_LANES*RESULT_WIDTH, o_dn_mask out NUM_LANES, o_dn_last out 1, i_dn_ready in 1; these form the downstream stream.
REQ-009 SHALL have ports: o_busy out 1, state != IDLE; o_err_capture out 1, sticky error flag.

Function
REQ-010 A beat SHALL transfer on a port when valid and ready are both high on a rising clock edge.
REQ-011 States SHALL be IDLE, FWD and OWN; o_busy SHALL be high in FWD and OWN.
REQ-012 In IDLE, i_capture SHALL latch i_result into the local bank; next state SHALL be OWN if IS_HEAD=1, else FWD.
REQ-013 If i_bypass=1 at capture, the bank SHALL NOT load, and the PE SHALL forward upstream only; it SHALL return to IDLE after passing the upstream last beat with o_dn_last intact.
REQ-014 In FWD, each upstream beat SHALL appear on the downstream port one cycle later, with data and mask unchanged; o_dn_last SHALL be forced to 0 unless bypassed.
REQ-015 After the upstream beat with i_up_last=1 is accepted, the next state SHALL be OWN.
REQ-016 OWN SHALL emit ceil(NUM_ACCUM/NUM_LANES) beats; lane l of beat b SHALL carry bank[b*NUM_LANES+l].
REQ-017 Unused lanes of the final partial beat SHALL have data 0 and mask 0; all other mask bits SHALL be 1.
REQ-018 The final OWN beat SHALL have o_dn_last=1; on its acceptance the state SHALL return to IDLE.
REQ-019 The output SHALL be a single register stage; it SHALL load when !o_dn_valid || i_dn_ready.
REQ-020 o_up_ready SHALL equal (state==FWD) && (!o_dn_valid || i_dn_ready); it SHALL be 0 in IDLE and OWN, and always 0 when IS_HEAD=1.
REQ-021 o_dn_valid SHALL stay high and o_dn_data, o_dn_mask and o_dn_last SHALL stay stable while i_dn_ready=0.
REQ-022 i_capture while o_busy=1 SHALL be ignored, with the bank unchanged, and SHALL set o_err_capture; only reset SHALL clear it.
REQ-023 An i_capture in the same cycle the final beat is accepted SHALL be treated as busy (REQ-022).
REQ-024 Latency SHALL be: capture at edge N gives o_dn_valid=1 after edge N+1 for the head, with zero bubbles between beats when i_dn_ready=1.
REQ-025 The beat counter SHALL be $clog2 of the beat count, minimum 1 bit, and SHALL wrap to 0 on IDLE entry.

Reset
REQ-026 While resetn=0, state SHALL be IDLE; o_dn_valid, o_dn_last, o_up_ready, o_busy and o_err_capture SHALL be 0; o_dn_data and o_dn_mask SHALL be 0; the beat counter SHALL be 0.
REQ-027 Reset mid-drain SHALL abort immediately without completing the packet; the bank contents need not be cleared.

Structure
REQ-028 The state enum and a beat-count function ceil(NUM_ACCUM/NUM_LANES) SHALL live in pe_types.
REQ-029 The output register stage SHALL be one sub-module, pe_stream_reg, parametrised by payload width.

Verification
REQ-030 Head, NUM_ACCUM=8, NUM_LANES=4, results 1..8, ready=1: two beats {1,2,3,4} mask F last 0, then {5,6,7,8} mask F last 1, on consecutive cycles.
REQ-031 NUM_ACCUM=6, NUM_LANES=4: second beat SHALL be {5,6,0,0} with mask 4'b0011 and last=1.
REQ-032 Non-head, upstream sends 2 beats (last on 2nd), own results 9..16: output SHALL be 4 beats, last only on 4th, with upstream data unchanged.
REQ-033 i_dn_ready toggled 1,0,0,1 during the drain: no beat lost or duplicated, and outputs held stable while ready=0.
REQ-034 i_bypass=1 with 1 upstream beat, last=1: exactly 1 output beat with last=1, then IDLE; the bank is not loaded.
REQ-035 i_capture while busy: o_err_capture=1 and the packet is unchanged; resetn pulsed mid-OWN: o_dn_valid=0 and state IDLE within the same cycle.
